// File: rtl/gf2m_digit_mult.sv
`default_nettype none
// ============================================================================
// Module  : gf2m_digit_mult
// Brief   : MSB-first digit-serial multiplier over GF(2^163), polynomial basis,
//           f(x) = x^163 + x^7 + x^6 + x^3 + 1; D multiplier bits per cycle.
// Revision: 1.0
// ============================================================================
module gf2m_digit_mult #(
    parameter int M = 163,
    parameter int D = 8
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         start,
    input  logic [M-1:0] op_a,
    input  logic [M-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] result
);

    localparam int K  = (M + D - 1) / D;
    localparam int KD = K * D;
    localparam int CW = $clog2(K + 1);
    localparam logic [CW-1:0] C_LAST = CW'(K - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    // Low-order terms of f: x^163 folds back onto x^7 + x^6 + x^3 + 1.
    localparam logic [M-1:0]  C_FOLD = {{(M-8){1'b0}}, 8'hC9};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [M-1:0]    r_a;
    logic [KD-1:0]   r_b;
    logic [M-1:0]    r_acc;
    logic [CW-1:0]   r_cnt;

    logic [D-1:0]    w_digit;
    logic [KD-1:0]   w_b_ext;
    logic [M-1:0]    w_acc_shift;
    logic [M-1:0]    w_part;
    logic [M-1:0]    w_acc_nxt;

    // Multiply by x with a single fold of the overflow bit.
    function automatic logic [M-1:0] mul_x(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? C_FOLD : '0);
    endfunction

    // v * x^D mod f, as D successive single-bit folds so any D up to 32 is exact.
    function automatic logic [M-1:0] mul_xd(input logic [M-1:0] v);
        logic [M-1:0] t;
        t = v;
        for (int i = 0; i < D; i++) begin
            t = mul_x(t);
        end
        return t;
    endfunction

    // a * d mod f for a D-bit digit d, Horner form from the digit MSB down.
    function automatic logic [M-1:0] mul_digit(input logic [M-1:0] a,
                                               input logic [D-1:0] d);
        logic [M-1:0] t;
        t = '0;
        for (int i = D - 1; i >= 0; i--) begin
            t = mul_x(t);
            if (d[i]) begin
                t = t ^ a;
            end
        end
        return t;
    endfunction

    always_comb begin
        w_b_ext          = '0;
        w_b_ext[M-1:0]   = op_b;
        w_digit          = r_b[KD-1 -: D];
        w_acc_shift      = mul_xd(r_acc);
        w_part           = mul_digit(r_a, w_digit);
        w_acc_nxt        = w_acc_shift ^ w_part;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= op_a;
                        r_b     <= w_b_ext;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // The top digit of r_b is always the next one to consume.
                    r_acc <= w_acc_nxt;
                    r_b   <= r_b << D;
                    r_cnt <= r_cnt + C_ONE;
                    if (r_cnt == C_LAST) begin
                        result  <= w_acc_nxt;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gf2m_digit_mult.sv
`default_nettype none
// ============================================================================
// Module  : tb_gf2m_digit_mult
// Brief   : Directed and model-based checks of gf2m_digit_mult at D=8, 1, 32.
// Revision: 1.0
// ============================================================================
module tb_gf2m_digit_mult;

    localparam int M = 163;
    localparam logic [M-1:0] C_POLY_LOW = 163'hC9;
    localparam logic [M-1:0] C_ONE      = 163'h1;
    localparam logic [M-1:0] C_X        = 163'h2;
    localparam logic [M-1:0] C_ID_B     = 163'h2_A5A5A5A5_5A5A5A5A_12345678_9ABCDEF0_0F1E2D3C;

    logic         clk;
    logic         rst;
    logic         start;
    logic [M-1:0] op_a;
    logic [M-1:0] op_b;
    logic         busy,   done;
    logic         busy1,  done1;
    logic         busy32, done32;
    logic [M-1:0] result, result1, result32;

    int checks   = 0;
    int failures = 0;

    gf2m_digit_mult #(.M(M), .D(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result)
    );
    gf2m_digit_mult #(.M(M), .D(1)) dut_d1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy1), .done(done1), .result(result1)
    );
    gf2m_digit_mult #(.M(M), .D(32)) dut_d32 (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy32), .done(done32), .result(result32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [M-1:0] bit_pow(input int n);
        logic [M-1:0] t;
        t = '0;
        t[n] = 1'b1;
        return t;
    endfunction

    // Right-to-left shift-and-add reference: r = sum b[i] * (a * x^i mod f).
    function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M-1:0] s;
        r = '0;
        s = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ s;
            s = {s[M-2:0], 1'b0} ^ (s[M-1] ? C_POLY_LOW : '0);
        end
        return r;
    endfunction

    function automatic logic [M-1:0] rand_fe();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[M-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulse start for one cycle; edges counts the start edge plus every edge until done.
    task automatic do_mult(input logic [M-1:0] a, input logic [M-1:0] b,
                           output logic [M-1:0] r, output int edges, output int busy_cycles);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        busy_cycles = 0;
        while (!done && edges < 400) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
        end
        r = result;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, required 0/0/0", busy, done, result);
        end
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || result1 !== '0 ||
            busy32 !== 1'b0 || done32 !== 1'b0 || result32 !== '0) begin
            failures++;
            $display("FAIL reset_state_sweep: d1 %b/%b/%h d32 %b/%b/%h, required all 0",
                     busy1, done1, result1, busy32, done32, result32);
        end
    endtask

    task automatic test_identity();
        logic [M-1:0] r;
        int e, bc;
        do_mult(C_ONE, C_ID_B, r, e, bc);
        checks++;
        if (r !== C_ID_B) begin
            failures++;
            $display("FAIL identity_result: got %h, required %h", r, C_ID_B);
        end
        checks++;
        if (e !== 22) begin
            failures++;
            $display("FAIL identity_latency: got %0d edges, required 22", e);
        end
        checks++;
        if (bc !== 21) begin
            failures++;
            $display("FAIL identity_busy_cycles: got %0d, required 21", bc);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL identity_busy_in_done: got %b, required 0", busy);
        end
        tick();
        tick();
        checks++;
        if (done !== 1'b0 || result !== C_ID_B) begin
            failures++;
            $display("FAIL identity_pulse_hold: done=%b result=%h, required 0 / %h", done, result, C_ID_B);
        end
    endtask

    task automatic test_reduction();
        logic [M-1:0] r;
        int e, bc;
        do_mult(C_X, bit_pow(162), r, e, bc);
        checks++;
        if (r !== 163'hC9) begin
            failures++;
            $display("FAIL reduction_x163: got %h, required %h", r, 163'hC9);
        end
    endtask

    task automatic test_square();
        logic [M-1:0] r;
        int e, bc;
        do_mult(bit_pow(81), bit_pow(81), r, e, bc);
        checks++;
        if (r !== bit_pow(162)) begin
            failures++;
            $display("FAIL square_x81: got %h, required %h", r, bit_pow(162));
        end
        do_mult(bit_pow(82), bit_pow(82), r, e, bc);
        checks++;
        if (r !== 163'h192) begin
            failures++;
            $display("FAIL square_x82: got %h, required %h", r, 163'h192);
        end
    endtask

    task automatic test_zero();
        logic [M-1:0] r;
        int e, bc;
        do_mult('0, {M{1'b1}}, r, e, bc);
        checks++;
        if (r !== '0 || e !== 22) begin
            failures++;
            $display("FAIL zero_operand: got %h after %0d edges, required 0 after 22", r, e);
        end
    endtask

    task automatic test_random();
        logic [M-1:0] a, b, r1, r2, exp_r;
        int e, bc;
        for (int n = 0; n < 500; n++) begin
            a = rand_fe();
            b = rand_fe();
            exp_r = ref_mul(a, b);
            do_mult(a, b, r1, e, bc);
            checks++;
            if (r1 !== exp_r) begin
                failures++;
                $display("FAIL random_%0d: a=%h b=%h got %h, required %h", n, a, b, r1, exp_r);
            end
            do_mult(b, a, r2, e, bc);
            checks++;
            if (r2 !== exp_r) begin
                failures++;
                $display("FAIL commute_%0d: got %h, required %h", n, r2, exp_r);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int e;
        op_a  = C_X;
        op_b  = bit_pow(162);
        start = 1'b1;
        tick();
        start = 1'b0;
        e = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            e++;
        end
        op_a  = bit_pow(81);
        op_b  = bit_pow(81);
        start = 1'b1;
        tick();
        e++;
        start = 1'b0;
        while (!done && e < 400) begin
            tick();
            e++;
        end
        checks++;
        if (result !== 163'hC9 || e !== 22) begin
            failures++;
            $display("FAIL restart_ignored: result=%h after %0d edges, required %h after 22",
                     result, e, 163'hC9);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        op_a  = C_X;
        op_b  = bit_pow(162);
        start = 1'b1;
        tick();
        e = 1;
        while (!done && e < 400) begin
            tick();
            e++;
        end
        checks++;
        if (result !== 163'hC9 || e !== 22) begin
            failures++;
            $display("FAIL b2b_first: result=%h after %0d edges, required %h after 22",
                     result, e, 163'hC9);
        end
        op_a = bit_pow(82);
        op_b = bit_pow(82);
        tick();
        e = 1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b done=%b, required 1/0", busy, done);
        end
        while (!done && e < 400) begin
            tick();
            e++;
        end
        start = 1'b0;
        checks++;
        if (result !== 163'h192 || e !== 22) begin
            failures++;
            $display("FAIL b2b_second: result=%h after %0d edges, required %h after 22",
                     result, e, 163'h192);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [M-1:0] r;
        int e, bc, pulses;
        op_a  = bit_pow(81);
        op_b  = bit_pow(81);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            failures++;
            $display("FAIL reset_mid_state: busy=%b done=%b result=%h, required 0/0/0", busy, done, result);
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_done: got %0d done pulses, required 0", pulses);
        end
        do_mult(bit_pow(82), bit_pow(82), r, e, bc);
        checks++;
        if (r !== 163'h192 || e !== 22) begin
            failures++;
            $display("FAIL reset_mid_recover: got %h after %0d edges, required %h after 22", r, e, 163'h192);
        end
    endtask

    task automatic test_param_sweep();
        logic [M-1:0] va [2];
        logic [M-1:0] vb [2];
        logic [M-1:0] vr [2];
        logic [M-1:0] r8, r1, r32;
        int l8, l1, l32, e;
        va[0] = C_X;          vb[0] = bit_pow(162); vr[0] = 163'hC9;
        va[1] = bit_pow(82);  vb[1] = bit_pow(82);  vr[1] = 163'h192;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int v = 0; v < 2; v++) begin
            op_a  = va[v];
            op_b  = vb[v];
            start = 1'b1;
            tick();
            start = 1'b0;
            e  = 1;
            l8 = 0; l1 = 0; l32 = 0;
            r8 = '0; r1 = '0; r32 = '0;
            checks++;
            if (busy !== 1'b1 || busy1 !== 1'b1 || busy32 !== 1'b1) begin
                failures++;
                $display("FAIL sweep_busy_%0d: d8=%b d1=%b d32=%b, required 1/1/1", v, busy, busy1, busy32);
            end
            while ((l8 == 0 || l1 == 0 || l32 == 0) && e < 200) begin
                tick();
                e++;
                if (done   && l8  == 0) begin l8  = e; r8  = result;   end
                if (done1  && l1  == 0) begin l1  = e; r1  = result1;  end
                if (done32 && l32 == 0) begin l32 = e; r32 = result32; end
            end
            checks++;
            if (l8 !== 22 || l1 !== 164 || l32 !== 7) begin
                failures++;
                $display("FAIL sweep_latency_%0d: d8=%0d d1=%0d d32=%0d, required 22/164/7", v, l8, l1, l32);
            end
            checks++;
            if (r8 !== vr[v] || r1 !== vr[v] || r32 !== vr[v]) begin
                failures++;
                $display("FAIL sweep_result_%0d: d8=%h d1=%h d32=%h, required %h", v, r8, r1, r32, vr[v]);
            end
            tick();
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        @(negedge clk);
        test_reset();
        test_identity();
        test_reduction();
        test_square();
        test_zero();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
